// File: rtl/instq_pkg.sv
// Shared definitions for the instruction queue: field widths, entry layout and lane slicing.
package instq_pkg;

    localparam int unsigned PC_W      = 32;
    localparam int unsigned INST_W    = 32;
    localparam int unsigned ENTRY_W   = 96;
    localparam int unsigned MAX_LANES = 4;

    // Bit offsets of each field inside a packed entry
    localparam int unsigned INST_LSB = 0;
    localparam int unsigned NPC_LSB  = INST_LSB + INST_W;
    localparam int unsigned PC_LSB   = NPC_LSB + PC_W;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   npc;
        logic [INST_W-1:0] inst;
    } entry_t;

    typedef logic [MAX_LANES*32-1:0] lane_bus_t;

    function automatic logic [31:0] lane_slice(input lane_bus_t bus, input int unsigned k);
        return bus[k*32 +: 32];
    endfunction

endpackage

// File: rtl/inst_queue_if.sv
// Producer/consumer bundle for inst_queue; stat outputs exist only with INSTQ_STAT_EN.
interface inst_queue_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned ENQ_W = 2,
    parameter int unsigned DEQ_W = 2
);
    import instq_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                    flush;
    logic [ENQ_W-1:0]        enq_valid;
    logic [PC_W*ENQ_W-1:0]   enq_pc;
    logic [PC_W*ENQ_W-1:0]   enq_npc;
    logic [INST_W*ENQ_W-1:0] enq_inst;
    logic                    enq_ready;
    logic [DEQ_W-1:0]        deq_valid;
    logic [PC_W*DEQ_W-1:0]   deq_pc;
    logic [PC_W*DEQ_W-1:0]   deq_npc;
    logic [INST_W*DEQ_W-1:0] deq_inst;
    logic [DEQ_W-1:0]        deq_ack;
    logic [CNT_W-1:0]        count;
`ifdef INSTQ_STAT_EN
    logic [31:0]             stat_stall_cyc;
    logic [CNT_W-1:0]        stat_hwm;
`endif

    modport master (
        output flush, enq_valid, enq_pc, enq_npc, enq_inst, deq_ack,
`ifdef INSTQ_STAT_EN
        input  stat_stall_cyc, stat_hwm,
`endif
        input  enq_ready, deq_valid, deq_pc, deq_npc, deq_inst, count
    );

    modport slave (
        input  flush, enq_valid, enq_pc, enq_npc, enq_inst, deq_ack,
`ifdef INSTQ_STAT_EN
        output stat_stall_cyc, stat_hwm,
`endif
        output enq_ready, deq_valid, deq_pc, deq_npc, deq_inst, count
    );

endinterface

// File: rtl/instq_prefix_cnt.sv
// Length of the contiguous run of ones starting at bit 0.
module instq_prefix_cnt #(
    parameter  int unsigned W  = 2,
    localparam int unsigned CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits,
    output logic [CW-1:0] cnt
);

    logic run;

    always_comb begin
        cnt = '0;
        run = 1'b1;
        for (int unsigned i = 0; i < W; i++) begin
            run = run & bits[i];
            if (run) cnt = cnt + CW'(1);
        end
    end

endmodule

// File: rtl/inst_queue.sv
// Multi-lane circular instruction queue with flush; INSTQ_STAT_EN adds stall/high-water stats.
module inst_queue
    import instq_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned ENQ_W = 2,
    parameter int unsigned DEQ_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    inst_queue_if.slave q
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned ENQ_CW = $clog2(ENQ_W + 1);
    localparam int unsigned DEQ_CW = $clog2(DEQ_W + 1);

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    entry_t            mem [DEPTH];

    logic              enq_ready;
    logic [DEQ_W-1:0]  deq_valid;
    logic [ENQ_CW-1:0] n_enq_raw;
    logic [DEQ_CW-1:0] n_deq_raw;
    logic [CNT_W-1:0]  n_enq;
    logic [CNT_W-1:0]  n_deq;

    lane_bus_t pc_bus;
    lane_bus_t npc_bus;
    lane_bus_t inst_bus;

    assign pc_bus   = lane_bus_t'(q.enq_pc);
    assign npc_bus  = lane_bus_t'(q.enq_npc);
    assign inst_bus = lane_bus_t'(q.enq_inst);

    instq_prefix_cnt #(.W(ENQ_W)) u_enq_cnt (
        .bits (q.enq_valid),
        .cnt  (n_enq_raw)
    );

    instq_prefix_cnt #(.W(DEQ_W)) u_deq_cnt (
        .bits (q.deq_ack & deq_valid),
        .cnt  (n_deq_raw)
    );

    // Readiness looks only at the registered count, so a same-cycle dequeue never frees room
    assign enq_ready  = (count <= CNT_W'(DEPTH - ENQ_W));
    assign n_enq      = enq_ready ? CNT_W'(n_enq_raw) : '0;
    assign n_deq      = CNT_W'(n_deq_raw);
    assign count_next = count + n_enq - n_deq;

    always_comb begin
        deq_valid = '0;
        for (int unsigned k = 0; k < DEQ_W; k++) begin
            deq_valid[k] = (count > CNT_W'(k));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (q.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(n_deq);
            tail  <= tail + PTR_W'(n_enq);
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!q.flush) begin
            for (int unsigned k = 0; k < ENQ_W; k++) begin
                if (CNT_W'(k) < n_enq) begin
                    mem[tail + PTR_W'(k)] <= '{pc:   lane_slice(pc_bus, k),
                                               npc:  lane_slice(npc_bus, k),
                                               inst: lane_slice(inst_bus, k)};
                end
            end
        end
    end

    // Stale storage is never observable: lanes beyond the occupancy read as zero
    always_comb begin
        entry_t e;
        e          = '0;
        q.deq_pc   = '0;
        q.deq_npc  = '0;
        q.deq_inst = '0;
        for (int unsigned k = 0; k < DEQ_W; k++) begin
            if (deq_valid[k]) begin
                e = mem[head + PTR_W'(k)];
                q.deq_pc[k*PC_W +: PC_W]       = e.pc;
                q.deq_npc[k*PC_W +: PC_W]      = e.npc;
                q.deq_inst[k*INST_W +: INST_W] = e.inst;
            end
        end
    end

    assign q.enq_ready = enq_ready;
    assign q.deq_valid = deq_valid;
    assign q.count     = count;

`ifdef INSTQ_STAT_EN
    logic [31:0]      stall_cyc;
    logic [CNT_W-1:0] hwm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cyc <= '0;
            hwm       <= '0;
        end else begin
            if (q.enq_valid[0] && !enq_ready && (stall_cyc != '1)) begin
                stall_cyc <= stall_cyc + 32'd1;
            end
            if (!q.flush && (count_next > hwm)) begin
                hwm <= count_next;
            end
        end
    end

    assign q.stat_stall_cyc = stall_cyc;
    assign q.stat_hwm       = hwm;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Directed + random checks of inst_queue against a queue-based model; INSTQ_STAT_EN also checks stats.
module tb_inst_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned ENQ_W = 2;
    localparam int unsigned DEQ_W = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    inst_queue_if #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W)) bus ();

    inst_queue #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] inst;
    } ment_t;

    ment_t       mq[$];
    logic [31:0] popped[$];
    int unsigned checks = 0;
    int unsigned passed = 0;
    logic [31:0] m_stall = '0;
    int unsigned m_hwm = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic idle();
        bus.flush     = 1'b0;
        bus.enq_valid = '0;
        bus.enq_pc    = '0;
        bus.enq_npc   = '0;
        bus.enq_inst  = '0;
        bus.deq_ack   = '0;
    endtask

    task automatic set_enq(input logic [1:0] ev, input logic [31:0] pcb,
                           input logic [31:0] i0, input logic [31:0] i1);
        bus.enq_valid = ev;
        bus.enq_pc    = {pcb + 32'd4, pcb};
        bus.enq_npc   = {pcb + 32'd8, pcb + 32'd4};
        bus.enq_inst  = {i1, i0};
    endtask

    task automatic model_clear();
        mq.delete();
        m_stall = '0;
        m_hwm   = 0;
    endtask

    task automatic check_all();
        int unsigned sz;
        sz = mq.size();
        chk("count", 32'(bus.count), 32'(sz));
        chk("enq_ready", 32'(bus.enq_ready), 32'(DEPTH - sz >= ENQ_W));
        for (int unsigned k = 0; k < DEQ_W; k++) begin
            logic [31:0] epc, enpc, einst;
            epc = '0; enpc = '0; einst = '0;
            if (k < sz) begin
                epc   = mq[k].pc;
                enpc  = mq[k].npc;
                einst = mq[k].inst;
            end
            chk($sformatf("deq_valid[%0d]", k), 32'(bus.deq_valid[k]), 32'(k < sz));
            chk($sformatf("deq_pc[%0d]", k), bus.deq_pc[k*32 +: 32], epc);
            chk($sformatf("deq_npc[%0d]", k), bus.deq_npc[k*32 +: 32], enpc);
            chk($sformatf("deq_inst[%0d]", k), bus.deq_inst[k*32 +: 32], einst);
        end
`ifdef INSTQ_STAT_EN
        chk("stat_stall_cyc", bus.stat_stall_cyc, m_stall);
        chk("stat_hwm", 32'(bus.stat_hwm), 32'(m_hwm));
`endif
    endtask

    // Applies the queue's rules to the inputs currently driven; called just before the edge
    task automatic model_update();
        int unsigned avail, nd;
        bit rdy;
        avail = mq.size();
        rdy   = (DEPTH - avail >= ENQ_W);
        if (bus.enq_valid[0] && !rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (bus.flush) begin
            mq.delete();
        end else begin
            nd = 0;
            for (int unsigned k = 0; k < DEQ_W; k++) begin
                if (nd == k && bus.deq_ack[k] && k < avail) nd++;
            end
            for (int unsigned k = 0; k < nd; k++) begin
                popped.push_back(bus.deq_pc[k*32 +: 32]);
                void'(mq.pop_front());
            end
            if (rdy) begin
                for (int unsigned k = 0; k < ENQ_W; k++) begin
                    if (!bus.enq_valid[k]) break;
                    mq.push_back('{pc:   bus.enq_pc[k*32 +: 32],
                                   npc:  bus.enq_npc[k*32 +: 32],
                                   inst: bus.enq_inst[k*32 +: 32]});
                end
            end
        end
        if (mq.size() > m_hwm) m_hwm = mq.size();
    endtask

    task automatic step();
        #1;
        check_all();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int unsigned pushed, cyc;
        logic [31:0] next_pc;
        logic [1:0]  ev;

        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        model_clear();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_enq_ready", 32'(bus.enq_ready), 32'd1);
        chk("rst_deq_valid", 32'(bus.deq_valid), 32'd0);
        chk("rst_deq_pc", bus.deq_pc[31:0], 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Two-lane enqueue visible one cycle later
        set_enq(2'b11, 32'h100, 32'hAAAA_0001, 32'hAAAA_0002);
        step();
        idle();
        chk("first_count", 32'(bus.count), 32'd2);
        chk("first_deq_valid", 32'(bus.deq_valid), 32'd3);
        chk("first_pc0", bus.deq_pc[31:0], 32'h100);
        chk("first_pc1", bus.deq_pc[63:32], 32'h104);

        set_enq(2'b11, 32'h108, 32'h1, 32'h2);
        step();

        // Simultaneous enqueue of two and dequeue of one at count 4
        set_enq(2'b11, 32'h110, 32'h3, 32'h4);
        bus.deq_ack = 2'b01;
        step();
        idle();
        chk("mix_count", 32'(bus.count), 32'd5);
        chk("mix_pc0", bus.deq_pc[31:0], 32'h104);

        set_enq(2'b11, 32'h118, 32'h5, 32'h6);
        step();
        idle();
        chk("seven_count", 32'(bus.count), 32'd7);
        chk("seven_ready", 32'(bus.enq_ready), 32'd0);

        set_enq(2'b11, 32'h120, 32'h7, 32'h8);
        repeat (3) step();
        idle();
        chk("hold_count", 32'(bus.count), 32'd7);
`ifdef INSTQ_STAT_EN
        chk("hold_stall", bus.stat_stall_cyc, 32'd3);
`endif

        bus.deq_ack = 2'b01;
        step();
        idle();
        chk("six_count", 32'(bus.count), 32'd6);

        // Flush beats same-cycle enqueue and dequeue
        bus.flush = 1'b1;
        set_enq(2'b11, 32'h200, 32'h9, 32'hA);
        bus.deq_ack = 2'b11;
        step();
        idle();
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_deq_valid", 32'(bus.deq_valid), 32'd0);
        chk("flush_pc", bus.deq_pc, 32'd0);
        chk("flush_inst", bus.deq_inst[31:0], 32'd0);

        // Gapped enqueue/ack patterns and an all-zero instruction
        set_enq(2'b10, 32'h300, 32'h0, 32'h0);
        bus.deq_ack = 2'b10;
        step();
        idle();
        chk("gap_count", 32'(bus.count), 32'd0);
        set_enq(2'b01, 32'h304, 32'h0, 32'h0);
        step();
        idle();
        chk("zero_count", 32'(bus.count), 32'd1);
        chk("zero_valid", 32'(bus.deq_valid), 32'd1);
        chk("zero_pc", bus.deq_pc[31:0], 32'h304);
        chk("zero_inst", bus.deq_inst[31:0], 32'h0);
        bus.deq_ack = 2'b10;
        step();
        chk("hiack_count", 32'(bus.count), 32'd1);
        bus.deq_ack = 2'b01;
        step();
        idle();
        chk("drain_count", 32'(bus.count), 32'd0);

        // Stream 20 sequential pcs through the wrapping buffer
        popped.delete();
        pushed  = 0;
        cyc     = 0;
        next_pc = 32'h1000;
        while (popped.size() < 20 && cyc < 400) begin
            ev = (pushed >= 20) ? 2'b00 : 2'($urandom_range(0, 3));
            if (20 - pushed == 1) ev = ev & 2'b01;
            set_enq(ev, next_pc, $urandom, $urandom);
            bus.deq_ack = 2'($urandom_range(0, 3));
            if (DEPTH - mq.size() >= ENQ_W) begin
                if (ev == 2'b11) begin
                    pushed += 2; next_pc += 32'd8;
                end else if (ev[0]) begin
                    pushed += 1; next_pc += 32'd4;
                end
            end
            step();
            cyc++;
        end
        idle();
        chk("stream_len", 32'(popped.size()), 32'd20);
        for (int unsigned i = 0; i < popped.size() && i < 20; i++) begin
            chk($sformatf("stream_pc[%0d]", i), popped[i], 32'h1000 + 32'(4 * i));
        end

        // Random traffic with occasional flush
        for (int i = 0; i < 150; i++) begin
            set_enq(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
            bus.deq_ack = 2'($urandom_range(0, 3));
            bus.flush   = ($urandom_range(0, 19) == 0);
            step();
        end
        idle();

        // Asynchronous reset in mid-operation
        set_enq(2'b11, 32'h500, 32'h11, 32'h12);
        repeat (2) step();
        idle();
        #3 rst = 1'b1;
        #1;
        model_clear();
        chk("arst_count", 32'(bus.count), 32'd0);
        chk("arst_deq_valid", 32'(bus.deq_valid), 32'd0);
        chk("arst_enq_ready", 32'(bus.enq_ready), 32'd1);
        chk("arst_deq_pc", bus.deq_pc[31:0], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_enq(2'b01, 32'h600, 32'h13, 32'h14);
        step();
        idle();
        step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
